// File: rtl/delay_ctrl_pkg.sv
// Shared types and sizes for the delay controller and its delay line.
// Entries pair a valid bit with the sample so bubbles travel alongside data.
package delay_ctrl_pkg;

  localparam int DATA_W    = 4;
  localparam int MAX_DELAY = 7;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dat;
  } entry_t;

  // A requested delay of zero is treated as the shortest legal delay.
  function automatic logic [CNT_W-1:0] legal_delay(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

endpackage

// File: rtl/delay_ctrl_if.sv
// Handshake, configuration and result signals of the delay controller.
// master drives stimulus and configuration; slave is the controller side.
interface delay_ctrl_if;
  import delay_ctrl_pkg::*;

  logic              cfg_we;
  logic [CNT_W-1:0]  cfg_delay;
  logic              start;
  logic              stop;
  logic              in_valid;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport master (
    output cfg_we, cfg_delay, start, stop, in_valid, in,
    input  out1, out2, out_valid, busy, done
  );

  modport slave (
    input  cfg_we, cfg_delay, start, stop, in_valid, in,
    output out1, out2, out_valid, busy, done
  );

endinterface

// File: rtl/delay_ctrl_line.sv
// Seven-entry shift line of {valid, data}; tap output is combinational from the registers.
// Shifts only when enabled, flush clears every entry; no backpressure.
module delay_stage_line
  import delay_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             flush,
  input  entry_t           din,
  input  logic [CNT_W-1:0] tap,
  output entry_t           dout
);

  entry_t line [1:MAX_DELAY];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        line[k] <= '0;
      end
    end else if (shift_en) begin
      line[1] <= din;
      for (int k = 2; k <= MAX_DELAY; k++) begin
        line[k] <= line[k-1];
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (tap == CNT_W'(k)) begin
        dout = line[k];
      end
    end
  end

endmodule

// File: rtl/delay_ctrl.sv
// Session FSM around a programmable delay line: out1 is the input delayed D cycles, out2 D+1.
// Single-cycle throughput, no backpressure; start/cfg only take effect when idle.
module delay_ctrl
  import delay_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  delay_ctrl_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] d_reg, d_nxt;
  logic             done_int;
  logic [DATA_W-1:0] out2_q;
  entry_t           din, tap_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      d_reg  <= CNT_W'(1);
      out2_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      d_reg  <= d_nxt;
      out2_q <= tap_out.dat;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d_reg;
    done_int  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // cfg and start in the same cycle: the new delay governs this session.
        if (bus.cfg_we) d_nxt = legal_delay(bus.cfg_delay);
        if (bus.start) begin
          state_nxt = S_FILL;
          cnt_nxt   = '0;
        end
      end
      S_FILL: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (bus.stop) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else if (cnt == d_reg - CNT_W'(1)) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == d_reg - CNT_W'(1)) begin
          state_nxt = S_IDLE;
          done_int  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Invalid samples enter as all-zero bubbles so out1 reads 0 for them.
  assign din = (state != S_DRAIN && bus.in_valid) ? {1'b1, bus.in} : '0;

  // Flushing on DRAIN exit also clears entries beyond the tap.
  delay_stage_line u_line (
    .clk      (clk),
    .rst      (rst),
    .shift_en (state != S_IDLE),
    .flush    (done_int),
    .din      (din),
    .tap      (d_reg),
    .dout     (tap_out)
  );

  assign bus.out1      = tap_out.dat;
  assign bus.out_valid = tap_out.vld;
  assign bus.out2      = out2_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_int;

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed bench for delay_ctrl: hand-computed expectations checked with immediate assertions.
module tb_delay_ctrl;
  import delay_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;

  always #5 clk = ~clk;

  delay_ctrl_if bus ();

  delay_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d);
    bus.in_valid = v;
    bus.in       = d;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] o1, input logic v, input logic [3:0] o2);
    chk({tag, ".out1"}, bus.out1, o1);
    chk({tag, ".vld"},  {3'b0, bus.out_valid}, {3'b0, v});
    chk({tag, ".out2"}, bus.out2, o2);
  endtask

  task automatic chk_ctl(input string tag, input logic b, input logic d);
    chk({tag, ".busy"}, {3'b0, bus.busy}, {3'b0, b});
    chk({tag, ".done"}, {3'b0, bus.done}, {3'b0, d});
  endtask

  function automatic logic any_line_vld();
    return dut.u_line.line[1].vld | dut.u_line.line[2].vld | dut.u_line.line[3].vld |
           dut.u_line.line[4].vld | dut.u_line.line[5].vld | dut.u_line.line[6].vld |
           dut.u_line.line[7].vld;
  endfunction

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_delay = '0; bus.start = 1'b0; bus.stop = 1'b0;
    drive(1'b0, 4'h0);
    tick();
    chk_out("rst", 4'h0, 1'b0, 4'h0);
    chk_ctl("rst", 1'b0, 1'b0);
    chk("rst.state", 4'(dut.state), 4'(S_IDLE));
    rst = 1'b0;

    // D=1 via cfg_delay=0, cfg and start together
    bus.cfg_we = 1'b1; bus.cfg_delay = 3'd0; bus.start = 1'b1;
    tick();
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    chk_ctl("d1.start", 1'b1, 1'b0);
    drive(1'b1, 4'h2); tick(); chk_out("d1.s0", 4'h2, 1'b1, 4'h0);
    drive(1'b1, 4'h3); tick(); chk_out("d1.s1", 4'h3, 1'b1, 4'h2);
    drive(1'b1, 4'h1); tick(); chk_out("d1.s2", 4'h1, 1'b1, 4'h3);
    drive(1'b1, 4'h4); tick(); chk_out("d1.s3", 4'h4, 1'b1, 4'h1);
    drive(1'b0, 4'h0); bus.stop = 1'b1;
    tick(); bus.stop = 1'b0;
    chk_out("d1.drain", 4'h0, 1'b0, 4'h4);
    chk_ctl("d1.drain", 1'b1, 1'b1);
    tick();
    chk_ctl("d1.idle", 1'b0, 1'b0);
    chk_out("d1.idle", 4'h0, 1'b0, 4'h0);

    // D=3, start and stop together in IDLE: start wins
    bus.cfg_we = 1'b1; bus.cfg_delay = 3'd3; tick(); bus.cfg_we = 1'b0;
    chk_ctl("d3.cfg", 1'b0, 1'b0);
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    chk("d3.c0.state", 4'(dut.state), 4'(S_FILL));
    drive(1'b1, 4'h2); tick(); chk_out("d3.c1", 4'h0, 1'b0, 4'h0);
    chk("d3.c1.state", 4'(dut.state), 4'(S_FILL));
    drive(1'b1, 4'h3); tick(); chk_out("d3.c2", 4'h0, 1'b0, 4'h0);
    chk("d3.c2.state", 4'(dut.state), 4'(S_FILL));
    drive(1'b1, 4'h1); tick(); chk_out("d3.c3", 4'h2, 1'b1, 4'h0);
    chk("d3.c3.state", 4'(dut.state), 4'(S_RUN));
    drive(1'b1, 4'h4); tick(); chk_out("d3.c4", 4'h3, 1'b1, 4'h2);
    drive(1'b0, 4'h0); bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk_out("d3.c5", 4'h1, 1'b1, 4'h3); chk_ctl("d3.c5", 1'b1, 1'b0);
    tick(); chk_out("d3.c6", 4'h4, 1'b1, 4'h1); chk_ctl("d3.c6", 1'b1, 1'b0);
    tick(); chk_out("d3.c7", 4'h0, 1'b0, 4'h4); chk_ctl("d3.c7", 1'b1, 1'b1);
    tick(); chk_out("d3.c8", 4'h0, 1'b0, 4'h0); chk_ctl("d3.c8", 1'b0, 1'b0);
    chk("d3.flushed", {3'b0, any_line_vld()}, 4'h0);

    // cfg_we and start while busy are ignored
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    drive(1'b1, 4'h7); tick();
    drive(1'b0, 4'h0); tick();
    tick(); chk_out("busy.c3", 4'h7, 1'b1, 4'h0);
    drive(1'b1, 4'h9); bus.cfg_we = 1'b1; bus.cfg_delay = 3'd5; tick(); bus.cfg_we = 1'b0;
    drive(1'b1, 4'h5); bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("busy.c5.state", 4'(dut.state), 4'(S_RUN));
    chk_out("busy.c5", 4'h0, 1'b0, 4'h0);
    drive(1'b1, 4'h6); tick();
    chk_out("busy.c6", 4'h9, 1'b1, 4'h0);

    // reset mid-RUN with data in flight
    rst = 1'b1; tick(); rst = 1'b0; drive(1'b0, 4'h0);
    chk_out("midrst", 4'h0, 1'b0, 4'h0);
    chk_ctl("midrst", 1'b0, 1'b0);
    chk("midrst.state", 4'(dut.state), 4'(S_IDLE));

    // D=2, in_valid pattern 1,0,1
    bus.cfg_we = 1'b1; bus.cfg_delay = 3'd2; bus.start = 1'b1; tick();
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    drive(1'b1, 4'hA); tick(); chk_out("d2.c1", 4'h0, 1'b0, 4'h0);
    drive(1'b0, 4'hB); tick(); chk_out("d2.c2", 4'hA, 1'b1, 4'h0);
    drive(1'b1, 4'hC); tick(); chk_out("d2.c3", 4'h0, 1'b0, 4'hA);
    drive(1'b0, 4'h0); tick(); chk_out("d2.c4", 4'hC, 1'b1, 4'h0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk_ctl("d2.c5", 1'b1, 1'b0);
    tick(); chk_ctl("d2.c6", 1'b1, 1'b1);
    tick(); chk_ctl("d2.c7", 1'b0, 1'b0);
    chk("d2.flushed", {3'b0, any_line_vld()}, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
